// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: round-robin arbiter and sequencer for the single external
// SRAM port, shared by port 0 (template/input loader) and port 1 (DTW core).
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   req<n>_i/we<n>_i/addr<n>_i/wdata<n>_i   requester n transaction, held until gnt<n>_o
//   gnt<n>_o                          combinational accept, only in IDLE
//   rvalid<n>_o                       one-cycle pulse, rdata_o valid for requester n
//   rdata_o                           registered read data, shared by both ports
//   addr_o, data_o, data_i            external address / write data / read data
//   data_tri_ena, WR_o, CS_o          pad drive enable, write strobe, chip select
//
// Cycle map: grant (IDLE) -> ACCESS (1) -> RWAIT (RD_LAT, reads only)
//            -> TURN (TURN cycles, reads only) -> IDLE.
module ext_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int TURN   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  output logic              gnt0_o,
  output logic              rvalid0_o,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt1_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              data_tri_ena,
  output logic              WR_o,
  output logic              CS_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RWAIT, S_TURN} state_t;

  // Counters load "cycles - 1" and leave their state when they reach zero.
  localparam logic [2:0] RWAIT_INIT = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;
  localparam logic [2:0] TURN_INIT  = (TURN > 0)   ? 3'(TURN - 1)   : 3'd0;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                last_q, last_d;   // 1 = port 1 owned the bus last
  logic                id_q, id_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                cs_q, cs_d;
  logic                wr_q, wr_d;
  logic                tri_q, tri_d;
  logic                rv0_q, rv0_d;
  logic                rv1_q, rv1_d;

  logic                gnt0, gnt1, grant, gid, sel_we, sample;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  state_t              after_read;

  always_comb begin
    gnt0      = !rst_i && (state_q == S_IDLE) && req0_i && (!req1_i || last_q);
    gnt1      = !rst_i && (state_q == S_IDLE) && req1_i && (!req0_i || !last_q);
    grant     = gnt0 | gnt1;
    gid       = gnt1;
    sel_we    = gid ? we1_i    : we0_i;
    sel_addr  = gid ? addr1_i  : addr0_i;
    sel_wdata = gid ? wdata1_i : wdata0_i;

    // data_i is captured on the edge that ends the last cycle with CS_o held
    // for a read: ACCESS itself when RD_LAT is 0, otherwise the final RWAIT.
    sample = ((state_q == S_ACCESS) && !we_q && (RD_LAT == 0)) ||
             ((state_q == S_RWAIT) && (cnt_q == '0));
    after_read = (TURN > 0) ? S_TURN : S_IDLE;

    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;

    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d = S_ACCESS;
          id_d    = gid;
          last_d  = gid;
          we_d    = sel_we;
          addr_d  = sel_addr;
          if (sel_we) data_d = sel_wdata;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d = S_IDLE;
        end else if (RD_LAT == 0) begin
          state_d = after_read;
          cnt_d   = TURN_INIT;
        end else begin
          state_d = S_RWAIT;
          cnt_d   = RWAIT_INIT;
        end
      end
      S_RWAIT: begin
        if (cnt_q == '0) begin
          state_d = after_read;
          cnt_d   = TURN_INIT;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_TURN: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Bus controls are registered from the next state so they are glitch-free
    // and line up exactly with the ACCESS/RWAIT cycles.
    cs_d    = (state_d == S_ACCESS) || (state_d == S_RWAIT);
    wr_d    = (state_d == S_ACCESS) && we_d;
    tri_d   = (state_d == S_ACCESS) && we_d;
    rdata_d = sample ? data_i : rdata_q;
    rv0_d   = sample && !id_q;
    rv1_d   = sample &&  id_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      tri_q   <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      tri_q   <= tri_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  assign gnt0_o       = gnt0;
  assign gnt1_o       = gnt1;
  assign rvalid0_o    = rv0_q;
  assign rvalid1_o    = rv1_q;
  assign rdata_o      = rdata_q;
  assign addr_o       = addr_q;
  assign data_o       = data_q;
  assign data_tri_ena = tri_q;
  assign WR_o         = wr_q;
  assign CS_o         = cs_q;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
module tb_ext_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] init_val(input logic [9:0] a);
    return (a == 10'h3FF) ? 32'h12345678 : (32'hA5000000 | {22'd0, a});
  endfunction

  // Instance A: RD_LAT=1, TURN=1
  logic        a_rst, a_req0, a_we0, a_gnt0, a_rv0, a_req1, a_we1, a_gnt1, a_rv1;
  logic [9:0]  a_addr0, a_addr1, a_addr_o;
  logic [31:0] a_wdata0, a_wdata1, a_rdata, a_data_o, a_data_i;
  logic        a_tri, a_wr, a_cs;

  // Instance B: RD_LAT=0, TURN=0
  logic        b_rst, b_req0, b_we0, b_gnt0, b_rv0, b_req1, b_we1, b_gnt1, b_rv1;
  logic [9:0]  b_addr0, b_addr1, b_addr_o;
  logic [31:0] b_wdata0, b_wdata1, b_rdata, b_data_o, b_data_i;
  logic        b_tri, b_wr, b_cs;

  ext_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1), .TURN(1)) u_a (
    .clk_i(clk), .rst_i(a_rst),
    .req0_i(a_req0), .we0_i(a_we0), .addr0_i(a_addr0), .wdata0_i(a_wdata0),
    .gnt0_o(a_gnt0), .rvalid0_o(a_rv0),
    .req1_i(a_req1), .we1_i(a_we1), .addr1_i(a_addr1), .wdata1_i(a_wdata1),
    .gnt1_o(a_gnt1), .rvalid1_o(a_rv1),
    .rdata_o(a_rdata), .addr_o(a_addr_o), .data_o(a_data_o), .data_i(a_data_i),
    .data_tri_ena(a_tri), .WR_o(a_wr), .CS_o(a_cs)
  );

  ext_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(0), .TURN(0)) u_b (
    .clk_i(clk), .rst_i(b_rst),
    .req0_i(b_req0), .we0_i(b_we0), .addr0_i(b_addr0), .wdata0_i(b_wdata0),
    .gnt0_o(b_gnt0), .rvalid0_o(b_rv0),
    .req1_i(b_req1), .we1_i(b_we1), .addr1_i(b_addr1), .wdata1_i(b_wdata1),
    .gnt1_o(b_gnt1), .rvalid1_o(b_rv1),
    .rdata_o(b_rdata), .addr_o(b_addr_o), .data_o(b_data_o), .data_i(b_data_i),
    .data_tri_ena(b_tri), .WR_o(b_wr), .CS_o(b_cs)
  );

  // SRAM models: untouched locations return init_val(addr).
  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];
  bit          va [1024];
  bit          vb [1024];
  always @(posedge clk) begin
    if (a_cs && a_wr) begin mem_a[a_addr_o] <= a_data_o; va[a_addr_o] <= 1'b1; end
    if (b_cs && b_wr) begin mem_b[b_addr_o] <= b_data_o; vb[b_addr_o] <= 1'b1; end
  end
  assign a_data_i = va[a_addr_o] ? mem_a[a_addr_o] : init_val(a_addr_o);
  assign b_data_i = vb[b_addr_o] ? mem_b[b_addr_o] : init_val(b_addr_o);

  // Scoreboards: expected read data pushed at grant, popped on rvalid.
  logic [31:0] q_a0[$], q_a1[$], q_b0[$], q_b1[$];

  always @(negedge clk) begin
    if (a_rv0) begin
      if (q_a0.size() != 0) chk("a_rdata_port0", a_rdata, q_a0.pop_front());
      else chk("a_rvalid0_unexpected", 32'(a_rv0), 32'd0);
    end
    if (a_rv1) begin
      if (q_a1.size() != 0) chk("a_rdata_port1", a_rdata, q_a1.pop_front());
      else chk("a_rvalid1_unexpected", 32'(a_rv1), 32'd0);
    end
    if (b_rv0) begin
      if (q_b0.size() != 0) chk("b_rdata_port0", b_rdata, q_b0.pop_front());
      else chk("b_rvalid0_unexpected", 32'(b_rv0), 32'd0);
    end
    if (b_rv1) begin
      if (q_b1.size() != 0) chk("b_rdata_port1", b_rdata, q_b1.pop_front());
      else chk("b_rvalid1_unexpected", 32'(b_rv1), 32'd0);
    end
    chk("a_drive_on_read", 32'(a_tri & a_cs & ~a_wr), 32'd0);
    chk("b_drive_on_read", 32'(b_tri & b_cs & ~b_wr), 32'd0);
  end

  typedef struct {
    bit          port;
    bit          we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bit granted;
    bit prev_p0_read;
    int last_gnt_cyc;

    vecs[0]  = '{1'b0, 1'b1, 10'h001, 32'h00001111, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 10'h002, 32'h00002222, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 10'h3FF, 32'hFFFF0000, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 10'h001, 32'h0, 32'h00001111};
    vecs[4]  = '{1'b0, 1'b0, 10'h002, 32'h0, 32'h00002222};
    vecs[5]  = '{1'b0, 1'b0, 10'h3FF, 32'h0, 32'hFFFF0000};
    vecs[6]  = '{1'b0, 1'b0, 10'h007, 32'h0, 32'hA5000007};
    vecs[7]  = '{1'b1, 1'b0, 10'h001, 32'h0, 32'h00001111};
    vecs[8]  = '{1'b1, 1'b1, 10'h000, 32'h80000001, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 10'h000, 32'h0, 32'h80000001};
    vecs[10] = '{1'b1, 1'b0, 10'h3FE, 32'h0, 32'hA50003FE};
    vecs[11] = '{1'b0, 1'b0, 10'h3FF, 32'h0, 32'hFFFF0000};

    a_rst = 1'b1; b_rst = 1'b1;
    a_req0 = 0; a_we0 = 0; a_addr0 = '0; a_wdata0 = '0;
    a_req1 = 0; a_we1 = 0; a_addr1 = '0; a_wdata1 = '0;
    b_req0 = 0; b_we0 = 0; b_addr0 = '0; b_wdata0 = '0;
    b_req1 = 0; b_we1 = 0; b_addr1 = '0; b_wdata1 = '0;

    // Reset held two edges; request pending but must not be granted yet.
    tick(); tick();
    a_req0 = 1; a_we0 = 1; a_addr0 = 10'h155; a_wdata0 = 32'hDEADBEEF;
    @(negedge clk);
    chk("rst_cs", 32'(a_cs), 0);   chk("rst_wr", 32'(a_wr), 0);
    chk("rst_tri", 32'(a_tri), 0); chk("rst_gnt0", 32'(a_gnt0), 0);
    chk("rst_gnt1", 32'(a_gnt1), 0); chk("rst_rv0", 32'(a_rv0), 0);
    chk("rst_rv1", 32'(a_rv1), 0); chk("rst_addr", 32'(a_addr_o), 0);
    chk("rst_data", a_data_o, 0);  chk("rst_rdata", a_rdata, 0);

    // Single write, T0 = first cycle out of reset
    tick(); a_rst = 0; b_rst = 0;
    @(negedge clk);
    chk("wr_T0_gnt0", 32'(a_gnt0), 1); chk("wr_T0_gnt1", 32'(a_gnt1), 0);
    tick(); a_req0 = 0;
    @(negedge clk);
    chk("wr_T1_cs", 32'(a_cs), 1); chk("wr_T1_wr", 32'(a_wr), 1);
    chk("wr_T1_tri", 32'(a_tri), 1); chk("wr_T1_addr", 32'(a_addr_o), 32'h155);
    chk("wr_T1_data", a_data_o, 32'hDEADBEEF);

    // Single read by port 1, requested in the cycle after the write
    tick(); a_req1 = 1; a_we1 = 0; a_addr1 = 10'h3FF;
    @(negedge clk);
    chk("wr_T2_cs", 32'(a_cs), 0); chk("wr_T2_wr", 32'(a_wr), 0);
    chk("wr_T2_tri", 32'(a_tri), 0); chk("rd_T0_gnt1", 32'(a_gnt1), 1);
    if (a_gnt1) q_a1.push_back(32'h12345678);
    tick(); a_req1 = 0;
    @(negedge clk);
    chk("rd_T1_cs", 32'(a_cs), 1); chk("rd_T1_wr", 32'(a_wr), 0);
    chk("rd_T1_tri", 32'(a_tri), 0); chk("rd_T1_addr", 32'(a_addr_o), 32'h3FF);
    tick();
    @(negedge clk);
    chk("rd_T2_cs", 32'(a_cs), 1); chk("rd_T2_tri", 32'(a_tri), 0);
    chk("rd_T2_rv1", 32'(a_rv1), 0);
    tick(); a_req0 = 1; a_we0 = 1; a_addr0 = 10'h00A; a_wdata0 = 32'hCAFE0001;
    @(negedge clk);
    chk("rd_T3_rv1", 32'(a_rv1), 1); chk("rd_T3_rdata", a_rdata, 32'h12345678);
    chk("rd_T3_cs", 32'(a_cs), 0); chk("rd_T3_gnt0_turn", 32'(a_gnt0), 0);
    tick();
    @(negedge clk);
    chk("rd_T4_gnt0", 32'(a_gnt0), 1);
    tick(); a_req0 = 0;

    // Reset during RWAIT drops the read with no rvalid
    tick(); a_req1 = 1; a_we1 = 0; a_addr1 = 10'h3FF;
    @(negedge clk);
    chk("rstrd_gnt1", 32'(a_gnt1), 1);
    tick(); a_req1 = 0;
    tick(); a_rst = 1;
    @(negedge clk);
    chk("rstrd_rwait_cs", 32'(a_cs), 1);
    tick(); a_rst = 0;
    @(negedge clk);
    chk("rstrd_cs", 32'(a_cs), 0); chk("rstrd_addr", 32'(a_addr_o), 0);
    for (int i = 0; i < 4; i++) begin
      chk("rstrd_no_rv1", 32'(a_rv1), 0);
      tick();
      @(negedge clk);
    end

    // Contention: both ports write continuously, port 0 wins first
    tick();
    a_req0 = 1; a_we0 = 1; a_addr0 = 10'h010; a_wdata0 = 32'h11110000;
    a_req1 = 1; a_we1 = 1; a_addr1 = 10'h020; a_wdata1 = 32'h22220000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("cont_gnt0_%0d", i), 32'(a_gnt0), 32'((i % 4) == 0));
      chk($sformatf("cont_gnt1_%0d", i), 32'(a_gnt1), 32'((i % 4) == 2));
      tick();
    end
    a_req0 = 0; a_req1 = 0;
    tick();
    chk("mem_a_00A", mem_a[10'h00A], 32'hCAFE0001);
    chk("mem_a_010", mem_a[10'h010], 32'h11110000);
    chk("mem_a_020", mem_a[10'h020], 32'h22220000);
    chk("mem_a_155", mem_a[10'h155], 32'hDEADBEEF);

    // Table-driven on RD_LAT=0/TURN=0: each record requested right after the
    // previous grant, so back-to-back traffic is exercised.
    prev_p0_read = 0;
    last_gnt_cyc = 0;
    for (int i = 0; i < 12; i++) begin
      b_req0 = 0; b_req1 = 0;
      if (vecs[i].port == 1'b0) begin
        b_req0 = 1; b_we0 = vecs[i].we; b_addr0 = vecs[i].addr; b_wdata0 = vecs[i].wdata;
      end else begin
        b_req1 = 1; b_we1 = vecs[i].we; b_addr1 = vecs[i].addr; b_wdata1 = vecs[i].wdata;
      end
      granted = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if ((vecs[i].port == 1'b0) ? b_gnt0 : b_gnt1) begin
          granted = 1;
          break;
        end
        tick();
      end
      chk($sformatf("b_vec%0d_granted", i), 32'(granted), 1);
      if (granted) begin
        chk($sformatf("b_vec%0d_other_gnt", i),
            32'((vecs[i].port == 1'b0) ? b_gnt1 : b_gnt0), 0);
        if (prev_p0_read && vecs[i].port == 1'b0 && !vecs[i].we) begin
          chk($sformatf("b_vec%0d_gap", i), 32'(cyc - last_gnt_cyc), 2);
          chk($sformatf("b_vec%0d_rv0_with_gnt", i), 32'(b_rv0), 1);
        end
        if (!vecs[i].we) begin
          if (vecs[i].port == 1'b0) q_b0.push_back(vecs[i].exp);
          else                      q_b1.push_back(vecs[i].exp);
        end
        prev_p0_read = (vecs[i].port == 1'b0) && !vecs[i].we;
        last_gnt_cyc = cyc;
      end
      tick();
    end
    b_req0 = 0; b_req1 = 0;

    repeat (10) tick();
    @(negedge clk);
    chk("scoreboard_drained",
        32'(q_a0.size() + q_a1.size() + q_b0.size() + q_b1.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
